// File: rtl/bus_sched_pkg.sv
// Shared types and constants for the quota-based bus scheduler.
package bus_sched_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam int DEF_NUM_MST = 7;
  localparam int DEF_CNT_W   = 7;
  localparam int DEF_WINDOW  = 100;
  localparam int DEF_IDX_W   = 3;

  // OR of the indices of set bits; exact for one-hot input, 0 for zero input.
  function automatic logic [DEF_IDX_W-1:0] oh2idx(input logic [DEF_NUM_MST-1:0] oh);
    logic [DEF_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < DEF_NUM_MST; i++)
      if (oh[i]) idx = idx | DEF_IDX_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/bus_quota_scheduler_prio_pick.sv
// Combinational lowest-index picker: isolates the lowest set bit of req.
module prio_pick #(
  parameter int N = 7
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] pick,
  output logic         any
);

  assign pick = req & (~req + N'(1));
  assign any  = |req;

endmodule

// File: rtl/bus_quota_scheduler.sv
// Quota/window bus scheduler for NUM_MST masters with a transaction watchdog.
module bus_quota_scheduler #(
  parameter int NUM_MST = bus_sched_pkg::DEF_NUM_MST,
  parameter int CNT_W   = bus_sched_pkg::DEF_CNT_W,
  parameter int WINDOW  = bus_sched_pkg::DEF_WINDOW,
  parameter int TO_CYC  = 64,
  parameter int IDX_W   = bus_sched_pkg::DEF_IDX_W
) (
  input  logic                     sysClk,
  input  logic                     Breset,
  input  logic [NUM_MST-1:0]       need,
  input  logic [NUM_MST*CNT_W-1:0] quota_cfg,
  input  logic                     tdone,
  output logic [NUM_MST-1:0]       ack,
  output logic [IDX_W-1:0]         gnt_id,
  output logic                     busy,
  output logic                     timeout_err,
  output logic                     win_wrap,
  output logic [NUM_MST*CNT_W-1:0] usage
);
  import bus_sched_pkg::*;

  localparam int WIN_W = $clog2(WINDOW);
  localparam int WD_W  = $clog2(TO_CYC);

  state_t                          state_q, state_d;
  logic [NUM_MST-1:0]              ack_q, ack_d;
  logic [IDX_W-1:0]                gnt_q, gnt_d;
  logic [NUM_MST-1:0][CNT_W-1:0]   usage_q, usage_d;
  logic [WIN_W-1:0]                win_q, win_d;
  logic [WD_W-1:0]                 wd_q, wd_d;
  logic                            to_q, to_d;
  logic                            wrap_q, wrap_d;

  logic [NUM_MST-1:0] elig, elig_oh, req_oh, grant_oh;
  logic               elig_any, req_any, done;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_MST; i++)
      elig[i] = need[i] & (usage_q[i] < quota_cfg[i*CNT_W +: CNT_W]);
  end

  prio_pick #(.N(NUM_MST)) u_pick_elig (.req(elig), .pick(elig_oh), .any(elig_any));
  prio_pick #(.N(NUM_MST)) u_pick_req  (.req(need), .pick(req_oh),  .any(req_any));

  // Best-effort fallback keeps the bus busy when every requester is over quota.
  assign grant_oh = elig_any ? elig_oh : req_oh;

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    gnt_d   = gnt_q;
    usage_d = usage_q;
    win_d   = win_q;
    wd_d    = wd_q;
    to_d    = 1'b0;
    wrap_d  = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          ack_d   = grant_oh;
          gnt_d   = oh2idx(grant_oh);
          wd_d    = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // tdone has priority over a simultaneous watchdog expiry.
        if (tdone) begin
          done = 1'b1;
        end else if (wd_q == WD_W'(TO_CYC-1)) begin
          done = 1'b1;
          to_d = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      state_d = IDLE;
      ack_d   = '0;
      if (win_q == WIN_W'(WINDOW-1)) begin
        usage_d = '0;
        win_d   = '0;
        wrap_d  = 1'b1;
      end else begin
        win_d = win_q + WIN_W'(1);
        for (int i = 0; i < NUM_MST; i++)
          if (ack_q[i] && usage_q[i] != {CNT_W{1'b1}})
            usage_d[i] = usage_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sysClk or negedge Breset) begin
    if (!Breset) begin
      state_q <= IDLE;
      ack_q   <= '0;
      gnt_q   <= '0;
      usage_q <= '0;
      win_q   <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      gnt_q   <= gnt_d;
      usage_q <= usage_d;
      win_q   <= win_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
      wrap_q  <= wrap_d;
    end
  end

  assign ack         = ack_q;
  assign gnt_id      = gnt_q;
  assign busy        = (state_q == BUSY);
  assign timeout_err = to_q;
  assign win_wrap    = wrap_q;
  assign usage       = usage_q;

endmodule
